// File: rtl/sram_stream_reader.sv
// Sweeps an address window through a 1-cycle-latency SRAM read port and
// re-times the returned words onto a valid/ready stream with full backpressure.
module sram_stream_reader #(
    parameter int DWIDTH = 24,
    parameter int AWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   length,
    output logic              busy,
    output logic              done,
    output logic [AWIDTH-1:0] addr_r,
    input  logic [DWIDTH-1:0] data_i,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last
);

    localparam int CW = AWIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [AWIDTH-1:0] r_addr;
    logic [CW-1:0]     r_len;
    logic [CW-1:0]     r_issued;
    logic              r_rd_pend;
    logic              r_pend_last;

    logic [DWIDTH-1:0] r_fifo_data [2];
    logic [1:0]        r_fifo_last;
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;

    logic              w_start;
    logic              w_pop;
    logic              w_push;
    logic              w_issue;
    logic              w_issue_last;
    logic [CW-1:0]     w_issued_inc;
    logic [2:0]        w_occ;
    logic              w_room;

    assign w_start      = (r_state == S_IDLE) && start;
    assign w_pop        = m_valid && m_ready;
    assign w_push       = r_rd_pend;
    assign w_issued_inc = r_issued + CW'(1);
    assign w_issue_last = (w_issued_inc == r_len);

    // A read is only launched when its word is guaranteed a FIFO slot on
    // arrival, counting the read still in flight and any pop this cycle.
    assign w_occ   = {1'b0, r_count} + {2'b00, r_rd_pend};
    assign w_room  = (w_occ < (3'd2 + {2'b00, w_pop}));
    assign w_issue = (r_state == S_RUN) && (r_issued < r_len) && w_room;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = (length == '0) ? S_DONE : S_RUN;
            S_RUN:   if (w_issue && w_issue_last) w_next_state = S_DRAIN;
            S_DRAIN: if (w_pop && m_last) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_len       <= '0;
            r_issued    <= '0;
            r_rd_pend   <= 1'b0;
            r_pend_last <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr   <= base_addr;
                r_len    <= length;
                r_issued <= '0;
            end else if (w_issue) begin
                r_addr   <= r_addr + AWIDTH'(1);
                r_issued <= w_issued_inc;
            end
            r_rd_pend   <= w_issue;
            r_pend_last <= w_issue && w_issue_last;
        end
    end

    // NOTE: the two FIFO entries are reset too, so m_data reads zero out of
    // reset; a large RAM would normally be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) r_fifo_data[i] <= '0;
            r_fifo_last <= '0;
            r_wptr      <= 1'b0;
            r_rptr      <= 1'b0;
            r_count     <= '0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wptr] <= data_i;
                r_fifo_last[r_wptr] <= r_pend_last;
                r_wptr              <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign addr_r  = r_addr;
    assign m_valid = (r_count != 2'd0);
    assign m_data  = r_fifo_data[r_rptr];
    assign m_last  = m_valid && r_fifo_last[r_rptr];

endmodule

// File: tb/tb_sram_stream_reader.sv
// Directed bench for sram_stream_reader: a behavioural 1-cycle-latency SRAM
// feeds the DUT, and each scenario task checks the stream it produces.
module tb_sram_stream_reader;

    localparam int DW = 24;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] data_i;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    sram_stream_reader #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .addr_r    (addr_r),
        .data_i    (data_i),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [64];
    always @(posedge clk) data_i <= mem[addr_r];

    int n_checks = 0;
    int n_pass   = 0;

    // Results gathered by run_cmd for the scenario tasks to judge.
    logic [DW-1:0] beat_data [$];
    logic          beat_last [$];
    logic [AW-1:0] addr_seq  [$];
    int            done_cycle;
    int            done_count;
    int            busy_cycles;
    int            valid_cycles;
    int            stall_errs;
    logic          busy_after;

    // Cycle c is the clock period that closes at edge E0+c, where E0 samples start.
    task automatic run_cmd(input logic [AW-1:0] b, input logic [AW:0] len,
                           input bit rnd, input int restart_c);
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        beat_data.delete();
        beat_last.delete();
        addr_seq.delete();
        done_cycle   = -1;
        done_count   = 0;
        busy_cycles  = 0;
        valid_cycles = 0;
        stall_errs   = 0;
        busy_after   = 1'bx;
        prev_stall   = 1'b0;
        prev_data    = '0;
        prev_last    = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        base_addr = b;
        length    = len;
        m_ready   = 1'b1;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            start = (c == restart_c);
            if (start) begin
                base_addr = 6'd20;
                length    = 7'd5;
            end
            if (addr_seq.size() == 0 || addr_seq[$] != addr_r) addr_seq.push_back(addr_r);
            if (busy) busy_cycles++;
            if (m_valid) valid_cycles++;
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
                stall_errs++;
            if (done) begin
                done_count++;
                if (done_cycle < 0) done_cycle = c;
            end
            if (done_cycle > 0 && c == done_cycle + 1) busy_after = busy;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid && m_ready) begin
                beat_data.push_back(m_data);
                beat_last.push_back(m_last);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (done_cycle > 0 && c == done_cycle + 2) break;
        end
        start   = 1'b0;
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({busy, done, m_valid, m_last, m_data, addr_r} !== '0) begin
            $display("FAIL reset_held: outputs=%h expected 0",
                     {busy, done, m_valid, m_last, m_data, addr_r});
        end else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, m_valid, m_last, m_data, addr_r} !== '0) begin
            $display("FAIL reset_released: outputs=%h expected 0",
                     {busy, done, m_valid, m_last, m_data, addr_r});
        end else n_pass++;
    endtask

    task automatic test_basic();
        run_cmd(6'd4, 7'd8, 1'b0, 0);
        n_checks++;
        if (beat_data.size() !== 8) $display("FAIL basic_beats: got %0d want 8", beat_data.size());
        else n_pass++;
        for (int k = 0; k < 8 && k < beat_data.size(); k++) begin
            n_checks++;
            if (beat_data[k] !== 24'hA50004 + 24'(k) || beat_last[k] !== (k == 7)) begin
                $display("FAIL basic_beat%0d: data=%h last=%b want %h last=%b",
                         k, beat_data[k], beat_last[k], 24'hA50004 + 24'(k), (k == 7));
            end else n_pass++;
        end
        n_checks++;
        if (done_cycle !== 11) $display("FAIL basic_done_time: got cycle %0d want 11", done_cycle);
        else n_pass++;
        n_checks++;
        if (busy_after !== 1'b0) $display("FAIL basic_busy_after: got %b want 0", busy_after);
        else n_pass++;
        n_checks++;
        if (done_count !== 1) $display("FAIL basic_done_count: got %0d want 1", done_count);
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] exp_a;
        run_cmd(6'd60, 7'd8, 1'b0, 0);
        n_checks++;
        if (addr_seq.size() < 8) $display("FAIL wrap_addr_count: got %0d want >=8", addr_seq.size());
        else n_pass++;
        for (int k = 0; k < 8; k++) begin
            exp_a = 6'd60 + 6'(k);
            n_checks++;
            if (k >= addr_seq.size() || addr_seq[k] !== exp_a) begin
                $display("FAIL wrap_addr%0d: got %0d want %0d", k,
                         (k < addr_seq.size()) ? int'(addr_seq[k]) : -1, exp_a);
            end else n_pass++;
            n_checks++;
            if (k >= beat_data.size() || beat_data[k] !== 24'hA50000 + 24'(exp_a)) begin
                $display("FAIL wrap_data%0d: got %h want %h", k,
                         (k < beat_data.size()) ? beat_data[k] : 24'hxxxxxx,
                         24'hA50000 + 24'(exp_a));
            end else n_pass++;
        end
    endtask

    task automatic test_full_random();
        int bad_data;
        int bad_last;
        run_cmd(6'd0, 7'd64, 1'b1, 0);
        bad_data = 0;
        bad_last = 0;
        for (int k = 0; k < beat_data.size(); k++) begin
            if (beat_data[k] !== 24'hA50000 + 24'(k)) bad_data++;
            if (beat_last[k] !== (k == 63)) bad_last++;
        end
        n_checks++;
        if (beat_data.size() !== 64) $display("FAIL full_beats: got %0d want 64", beat_data.size());
        else n_pass++;
        n_checks++;
        if (bad_data !== 0) $display("FAIL full_order: %0d wrong words want 0", bad_data);
        else n_pass++;
        n_checks++;
        if (bad_last !== 0) $display("FAIL full_last: %0d wrong m_last want 0", bad_last);
        else n_pass++;
        n_checks++;
        if (stall_errs !== 0) $display("FAIL full_stall_stable: %0d violations want 0", stall_errs);
        else n_pass++;
        n_checks++;
        if (done_count !== 1) $display("FAIL full_done_count: got %0d want 1", done_count);
        else n_pass++;
    endtask

    task automatic test_zero_length();
        run_cmd(6'd7, 7'd0, 1'b0, 0);
        n_checks++;
        if (valid_cycles !== 0) $display("FAIL zero_valid: got %0d cycles want 0", valid_cycles);
        else n_pass++;
        n_checks++;
        if (busy_cycles !== 1) $display("FAIL zero_busy: got %0d cycles want 1", busy_cycles);
        else n_pass++;
        n_checks++;
        if (done_cycle !== 1) $display("FAIL zero_done_time: got cycle %0d want 1", done_cycle);
        else n_pass++;
    endtask

    task automatic test_ignored_start();
        run_cmd(6'd0, 7'd16, 1'b0, 3);
        n_checks++;
        if (beat_data.size() !== 16) $display("FAIL ignore_beats: got %0d want 16", beat_data.size());
        else n_pass++;
        for (int k = 0; k < 16 && k < beat_data.size(); k++) begin
            n_checks++;
            if (beat_data[k] !== 24'hA50000 + 24'(k)) begin
                $display("FAIL ignore_data%0d: got %h want %h", k, beat_data[k], 24'hA50000 + 24'(k));
            end else n_pass++;
        end
        n_checks++;
        if (done_count !== 1) $display("FAIL ignore_done_count: got %0d want 1", done_count);
        else n_pass++;
        run_cmd(6'd20, 7'd2, 1'b0, 0);
        n_checks++;
        if (beat_data.size() !== 2 || beat_data[0] !== 24'hA50014 || beat_data[1] !== 24'hA50015) begin
            $display("FAIL restart_after_done: got %0d beats first=%h want 2 beats A50014,A50015",
                     beat_data.size(), (beat_data.size() > 0) ? beat_data[0] : 24'hxxxxxx);
        end else n_pass++;
    endtask

    task automatic test_reset_abort();
        int   nbeats;
        logic saw_done;
        nbeats   = 0;
        saw_done = 1'b0;
        @(negedge clk);
        start     = 1'b1;
        base_addr = 6'd0;
        length    = 7'd10;
        m_ready   = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) saw_done = 1'b1;
            if (m_valid && m_ready) nbeats++;
            if (nbeats == 3) break;
        end
        n_checks++;
        if (nbeats !== 3) $display("FAIL abort_pre_beats: got %0d want 3", nbeats);
        else n_pass++;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, m_valid, m_last, m_data, addr_r} !== '0) begin
            $display("FAIL abort_outputs: outputs=%h expected 0",
                     {busy, done, m_valid, m_last, m_data, addr_r});
        end else n_pass++;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        n_checks++;
        if (saw_done !== 1'b0) $display("FAIL abort_no_done: got done=%b want 0", saw_done);
        else n_pass++;
        run_cmd(6'd8, 7'd2, 1'b0, 0);
        n_checks++;
        if (beat_data.size() !== 2) $display("FAIL abort_after_beats: got %0d want 2", beat_data.size());
        else n_pass++;
        n_checks++;
        if (beat_data.size() != 2 || beat_data[0] !== 24'hA50008 || beat_data[1] !== 24'hA50009 ||
            beat_last[0] !== 1'b0 || beat_last[1] !== 1'b1) begin
            $display("FAIL abort_after_data: first=%h want A50008/last0, second want A50009/last1",
                     (beat_data.size() > 0) ? beat_data[0] : 24'hxxxxxx);
        end else n_pass++;
        n_checks++;
        if (done_count !== 1) $display("FAIL abort_after_done: got %0d want 1", done_count);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 24'hA50000 + 24'(i);
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        m_ready   = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_full_random();
        test_zero_length();
        test_ignored_start();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_stream_reader.md
Name: sram_stream_reader

Overview:
- Read-side controller for the team's dual-port SRAM (DWIDTH x 2**AWIDTH, registered read port, 1-cycle read latency).
- On a start command, sweeps a contiguous address window through the SRAM read port.
- Absorbs the read latency and presents the words as a valid/ready stream with full backpressure support.
- Sits between the SRAM read port and any downstream consumer; writes stay on the SRAM write port, untouched by this block.

Parameters:
- DWIDTH, 24, SRAM word width and stream data width.
- AWIDTH, 6, SRAM address width; depth = 2**AWIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  command strobe, sampled on clk when idle.
- base_addr  input  AWIDTH  first address of the window, captured with start.
- length  input  AWIDTH+1  number of words, 0..2**AWIDTH, captured with start.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-cycle pulse at command completion.
- addr_r  output  AWIDTH  to SRAM addr_r.
- data_i  input  DWIDTH  from SRAM data_o.
- m_valid  output  1  stream word valid.
- m_ready  input  1  downstream accept.
- m_data  output  DWIDTH  stream word.
- m_last  output  1  high with the final word of the command.

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0, done=0, m_valid=0, m_last=0, m_data=0, addr_r=0; FIFO empty; counters 0.
- States:
  - IDLE: start=1 captures base_addr and length, then moves to RUN (length>0) or DONE (length=0).
  - RUN: issues reads.
  - DRAIN: all reads issued; waits for the FIFO and the in-flight read to empty.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start is ignored whenever state is not IDLE.
- addr_r is driven from the read-address counter register. An issue in cycle t means the SRAM samples addr_r at the end of t, and data_i is valid in cycle t+1. That word is pushed into a 2-entry output FIFO at the end of t+1.
- Issue rule: issue in cycle t iff state=RUN and issued<length and (fifo_count + rd_pend - pop) < 2.
  - pop = m_valid & m_ready in cycle t.
  - rd_pend = a read was issued in t-1.
  - No read is ever issued without a guaranteed FIFO slot, so no data is ever dropped.
- Address counter increments modulo 2**AWIDTH after each issue (wraps 2**AWIDTH-1 -> 0). addr_r holds its last value while not issuing.
- RUN -> DRAIN in the cycle after the last issue.
- m_valid = FIFO non-empty. m_data = FIFO head.
- Handshake:
  - A word transfers on m_valid & m_ready.
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
  - m_valid never drops without a transfer.
- m_last = 1 iff the head word is word number length-1 of the command.
- DRAIN -> DONE in the cycle after the m_last transfer. done pulses in that cycle; busy=0 from the following cycle.
- Latency (m_ready=1 throughout): start sampled at edge E0; first issue in the cycle after E0; first m_valid after E2. Sustained throughput is 1 word/cycle. For length N, done pulses N+3 cycles after E0.
- length=2**AWIDTH reads every location exactly once; the counter is AWIDTH+1 bits, so it never overflows.
- SRAM writes to the window during the sweep are not hazard-protected; the returned word is whatever the SRAM outputs for that read.
- rst_n asserted mid-operation: immediate return to reset values; in-flight data is discarded; no done pulse.

Test Plan:
- Preload mem[i]=0xA50000+i; start with base=4, length=8, m_ready=1 -> 8 consecutive beats 0xA50004..0xA5000B; m_last on beat 8 only; done 11 cycles after the start edge; busy low afterwards.
- Same preload; base=60, length=8 -> addr_r sequence 60,61,62,63,0,1,2,3; data 0xA5003C..0xA5003F then 0xA50000..0xA50003.
- base=0, length=64, m_ready random 50% -> exactly 64 beats in address order; no duplicates or drops; m_data/m_last stable during stalls; done once.
- length=0 -> no m_valid; busy for 1 cycle; done pulse in the cycle after start.
- start re-pulsed with base=20 while busy on a base=0, length=16 command -> ignored; 16 beats from address 0 only; a start after done is accepted.
- Assert rst_n=0 after 3 beats of a length-10 command, release, start base=8, length=2 -> all outputs zero during reset; no done for the aborted command; then exactly 2 beats mem[8], mem[9] with m_last on the second.
